int_wb_arbiter: RTL and testbench

//  Writeback stage directly downstream of the integer ALUs.
//  - Collects registered writeback packets (valwbInfo_t) from NUM_FU ALUs.
//  - Grants up to NUM_WBPORT packets per cycle, round-robin.
//  - Registers each granted packet onto a regfile/ROB writeback port.
//  - Drives each losing ALU's i_wb_stall so it holds its packet stable.

---
 rtl/int_wb_arbiter_pkg.sv | 33 +++
 rtl/int_wb_arbiter_picker.sv | 62 ++++++
 rtl/int_wb_arbiter.sv | 86 ++++++++
 tb/tb_int_wb_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/int_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_wb_arbiter_pkg
//  Description : Shared types and widths for the integer writeback arbiter
//                and its round-robin multi-grant picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_wb_arbiter_pkg;

  localparam int ROB_IDX_W  = 6;
  localparam int IROB_IDX_W = 5;
  localparam int IPRD_IDX_W = 7;
  localparam int XLEN       = 32;

  localparam int WBARB_NUM_FU     = 4;
  localparam int WBARB_NUM_WBPORT = 2;

  // Writeback packet produced by an integer ALU
  typedef struct packed {
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [IROB_IDX_W-1:0] irob_idx;
    logic                  rd_wen;
    logic [IPRD_IDX_W-1:0] iprd_idx;
    logic [XLEN-1:0]       result;
  } valwbInfo_t;

  // Index width for an N-entry source group; never narrower than one bit
  function automatic int wbarb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_wb_arbiter_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_multi_picker
//  Description : Combinational round-robin picker granting up to M of N
//                requesters, scanning from ptr_i upward with wrap-around.
//                The k-th grant in scan order is reported in slot k.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_multi_picker
  import int_wb_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int M  = 2,
  localparam int IW = wbarb_idx_w(N)
) (
  input  logic [N-1:0]         req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [M-1:0][IW-1:0] sel_idx_o,
  output logic [M-1:0]         sel_vld_o,
  output logic [IW-1:0]        last_idx_o
);

  localparam int IWP   = IW + 1;
  localparam int CNT_W = $clog2(M + 1);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Rotate requests so bit 0 is the FU at the round-robin pointer
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[ptr_i +: N];

  // Walk the rotated requests in priority order, handing out up to M slots
  always_comb begin
    logic [IWP-1:0]   pos;
    logic [CNT_W-1:0] cnt;
    grant_o    = '0;
    sel_idx_o  = '0;
    sel_vld_o  = '0;
    last_idx_o = '0;
    pos        = '0;
    cnt        = '0;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, ptr_i} + IWP'(off);
      if (pos >= IWP'(N)) pos = pos - IWP'(N);
      if (req_rot[off] && (cnt < CNT_W'(M))) begin
        grant_o[pos[IW-1:0]] = 1'b1;
        for (int k = 0; k < M; k++) begin
          if (cnt == CNT_W'(k)) begin
            sel_idx_o[k] = pos[IW-1:0];
            sel_vld_o[k] = 1'b1;
          end
        end
        last_idx_o = pos[IW-1:0];
        cnt        = cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : int_wb_arbiter
//  Description : Integer writeback arbiter. Grants up to NUM_WBPORT of the
//                NUM_FU ALU packets per cycle round-robin, registers them onto
//                the writeback ports and stalls the losing ALUs.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_wb_arbiter
  import int_wb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = WBARB_NUM_FU,
  parameter int NUM_WBPORT = WBARB_NUM_WBPORT
) (
  input  logic                        clk,
  input  logic                        rst,          // active-low, asynchronous
  input  logic                        i_flush,
  input  logic       [NUM_FU-1:0]     i_fu_vld,
  input  valwbInfo_t [NUM_FU-1:0]     i_fu_wbInfo,
  output logic       [NUM_FU-1:0]     o_fu_stall,
  output logic       [NUM_WBPORT-1:0] o_wb_vld,
  output valwbInfo_t [NUM_WBPORT-1:0] o_wbInfo
);

  localparam int WBARB_FUIDX_W = wbarb_idx_w(NUM_FU);

  logic       [WBARB_FUIDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic       [NUM_WBPORT-1:0]                    wb_vld_q, wb_vld_d;
  valwbInfo_t [NUM_WBPORT-1:0]                    wbinfo_q, wbinfo_d;

  logic       [NUM_FU-1:0]                        req;
  logic       [NUM_FU-1:0]                        grant;
  logic       [NUM_WBPORT-1:0][WBARB_FUIDX_W-1:0] sel_idx;
  logic       [NUM_WBPORT-1:0]                    sel_vld;
  logic       [WBARB_FUIDX_W-1:0]                 last_idx;

  // A flush removes every request so nothing is granted and the pointer holds
  assign req = i_fu_vld & ~{NUM_FU{i_flush}};

  rr_multi_picker #(
    .N (NUM_FU),
    .M (NUM_WBPORT)
  ) u_picker (
    .req_i      (req),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .sel_idx_o  (sel_idx),
    .sel_vld_o  (sel_vld),
    .last_idx_o (last_idx)
  );

  // Losers hold their packet; flush and reset release every ALU
  assign o_fu_stall = i_fu_vld & ~grant & ~{NUM_FU{i_flush}} & {NUM_FU{rst}};

  // Next port contents and pointer: resume scanning just past the last winner
  always_comb begin
    wb_vld_d = sel_vld;
    wbinfo_d = wbinfo_q;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_WBPORT; k++) begin
      if (sel_vld[k]) wbinfo_d[k] = i_fu_wbInfo[sel_idx[k]];
    end
    if (sel_vld[0]) begin
      if (last_idx == WBARB_FUIDX_W'(NUM_FU - 1)) rr_ptr_d = '0;
      else                                        rr_ptr_d = last_idx + WBARB_FUIDX_W'(1);
    end
  end

  // Writeback port and pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      wb_vld_q <= '0;
      wbinfo_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wb_vld_q <= wb_vld_d;
      wbinfo_q <= wbinfo_d;
    end
  end

  assign o_wb_vld = wb_vld_q;
  assign o_wbInfo = wbinfo_q;

endmodule
`default_nettype wire

// File: tb/tb_int_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_wb_arbiter
//  Description : Scoreboard bench for int_wb_arbiter (NUM_FU=4, NUM_WBPORT=2)
//                with directed scenarios followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_wb_arbiter;
  import int_wb_arbiter_pkg::*;

  localparam int NF = 4;
  localparam int NP = 2;

  typedef struct packed {
    logic       [NP-1:0] vld;
    valwbInfo_t [NP-1:0] pkt;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                flush = 1'b0;
  logic       [NF-1:0] fu_vld = '0;
  valwbInfo_t [NF-1:0] fu_info = '0;
  logic       [NF-1:0] fu_stall;
  logic       [NP-1:0] wb_vld;
  valwbInfo_t [NP-1:0] wb_info;

  exp_t                sb_q[$];
  valwbInfo_t          port_hold[NP];
  logic       [NF-1:0] held = '0;
  int                  m_ptr = 0;
  int                  n_cmp = 0;
  int                  n_err = 0;

  int_wb_arbiter #(.NUM_FU(NF), .NUM_WBPORT(NP)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_fu_vld    (fu_vld),
    .i_fu_wbInfo (fu_info),
    .o_fu_stall  (fu_stall),
    .o_wb_vld    (wb_vld),
    .o_wbInfo    (wb_info)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic valwbInfo_t rand_pkt();
    valwbInfo_t p;
    p.rob_idx  = 6'($urandom);
    p.irob_idx = 5'($urandom);
    p.rd_wen   = 1'($urandom);
    p.iprd_idx = 7'($urandom);
    p.result   = $urandom;
    return p;
  endfunction

  // One cycle of stimulus: ALUs that were stalled keep their packet and
  // stay valid; the reference model picks winners in round-robin order.
  task automatic step(input logic [NF-1:0] vld_req, input logic fl, input logic force_dead);
    logic [NF-1:0] vld;
    logic [NF-1:0] win;
    logic [NF-1:0] exp_stall;
    exp_t          e;
    int            cnt;
    int            last;
    int            idx;
    @(negedge clk);
    chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    vld = vld_req | held;
    for (int i = 0; i < NF; i++) if (!held[i]) fu_info[i] = rand_pkt();
    if (force_dead && !held[0]) begin
      fu_info[0].rd_wen = 1'b0;
      fu_info[0].result = 32'hDEAD;
    end
    fu_vld = vld;
    flush  = fl;
    #1;
    e    = '0;
    win  = '0;
    cnt  = 0;
    last = -1;
    if (!fl) begin
      for (int off = 0; off < NF; off++) begin
        idx = (m_ptr + off) % NF;
        if (vld[idx] && cnt < NP) begin
          e.vld[cnt] = 1'b1;
          e.pkt[cnt] = fu_info[idx];
          win[idx]   = 1'b1;
          last       = idx;
          cnt++;
        end
      end
    end
    if (last >= 0) m_ptr = (last + 1) % NF;
    exp_stall = fl ? '0 : (vld & ~win);
    chk("stall", 64'(fu_stall), 64'(exp_stall));
    held = exp_stall;
    sb_q.push_back(e);
  endtask

  // Monitor: compare each registered writeback against the queued expectation
  initial begin
    exp_t e;
    for (int k = 0; k < NP; k++) port_hold[k] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        if (sb_q.size() == 0) begin
          chk("idle_vld", 64'(wb_vld), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("wb_vld", 64'(wb_vld), 64'(e.vld));
          for (int k = 0; k < NP; k++) begin
            if (e.vld[k]) port_hold[k] = e.pkt[k];
            chk($sformatf("wb_info%0d", k), 64'(wb_info[k]), 64'(port_hold[k]));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with every ALU requesting
    rst    = 1'b0;
    fu_vld = '1;
    for (int i = 0; i < NF; i++) fu_info[i] = rand_pkt();
    repeat (2) @(negedge clk);
    chk("rst_wb_vld", 64'(wb_vld), 64'(0));
    chk("rst_stall", 64'(fu_stall), 64'(0));
    chk("rst_info0", 64'(wb_info[0]), 64'(0));
    chk("rst_info1", 64'(wb_info[1]), 64'(0));
    fu_vld = '0;
    rst    = 1'b1;

    // Saturation: expect (0,1),(2,3),(0,1),(2,3)
    repeat (4) step(4'b1111, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // Two requests from pointer 0 -> FU0,FU2, pointer becomes 3
    step(4'b0101, 1'b0, 1'b0);
    // Wrap from pointer 3 -> FU3,FU0, FU1 stalls, pointer becomes 1
    step(4'b1011, 1'b0, 1'b0);
    // Flush dominates all requests
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    // rd_wen=0 packet still completes
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      if (n == 200) begin
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_wb_vld", 64'(wb_vld), 64'(0));
        chk("midrst_stall", 64'(fu_stall), 64'(0));
        chk("midrst_info0", 64'(wb_info[0]), 64'(0));
        sb_q.delete();
        for (int k = 0; k < NP; k++) port_hold[k] = '0;
        m_ptr = 0;
        held  = '0;
        @(negedge clk);
        fu_vld = '0;
        flush  = 1'b0;
        rst    = 1'b1;
      end
    end

    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
